bitserial_operand_tx: RTL
=========================

# bitserial_operand_tx

Transmit end of the team's LSB-first bit-serial multiply-add array. Accepts a parallel operand pair through a valid/ready handshake and drives one operand onto the array as a bit-serial stream. The other operand is held parallel, one bit per array cell, for the whole frame. A `sync` pulse marks bit 0 of every frame so the serial cells clear their carry. Optional zero-padding cycles flush the full double-width product out of the array.

## Interface
Parameters:
- `W`, default 8: operand width in bits; minimum 2.
- `PAD`, default `W`: zero bits appended after the serial operand; used only when padding is compiled in.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: an operand pair is offered.
- `in_ready`, output, 1: the block can accept; a transfer occurs on any edge where `in_valid & in_ready`.
- `in_a`, input, `W`: operand to serialize.
- `in_b`, input, `W`: operand to hold parallel.
- `a_ser`, output, 1: serial operand bit, LSB first; registered.
- `b_par`, output, `W`: held parallel operand; registered.
- `sync`, output, 1: high exactly in frame cycle 0; registered.
- `busy`, output, 1: high during every frame cycle; registered.

## Operation
- Frame length F: `W+PAD` with padding compiled in, `W` without.
- Frame cycles 0..W-1: `a_ser = in_a[i]`.
- Frame cycles W..F-1: `a_ser = 0`.
- `b_par` is constant for the whole frame.
- FSM has three states.
  - IDLE goes to SHIFT on a transfer.
  - SHIFT steps through W cycles. It then goes to PAD, or ends the frame if padding is absent.
  - PAD steps through PAD cycles and then ends the frame.
  - At frame end the FSM goes to SHIFT of a new frame if a transfer occurs in the last cycle. Otherwise it goes to IDLE.
- Bit counter width is `$clog2(F)`. It resets to 0 at every frame start and never wraps inside a frame.
- `in_ready = (state==IDLE) | last_cycle`, where last_cycle is counter == F-1 in the final state. `in_ready` is combinational from registered state and never depends on `in_valid`.
- The operand shift register loads `in_a` on transfer and shifts right one bit per cycle. Zeros shift in from the MSB.
- In IDLE:
  - `a_ser=0`, `sync=0`, `busy=0`.
  - `b_par` holds its last value, so cells keep a stable operand.
- `in_valid` while not ready has no effect. Inputs are sampled only on a transfer edge.

## Timing
- Reset values:
  - `a_ser=0`, `sync=0`, `busy=0`, `b_par=0`, state IDLE, counter 0.
  - `in_ready=1` while in IDLE. Transfers are ignored while `rst_n` is low.
- Latency: on transfer at edge k, frame cycle 0 is visible immediately after edge k, with `sync=1`, `a_ser=in_a[0]`, `b_par=in_b`, `busy=1`.
- Frame cycle i is visible after edge k+i. The last frame cycle is visible after edge k+F-1.
- Back-to-back frames: a transfer at edge k+F-1 makes the next frame's cycle 0 visible after edge k+F. There is no gap cycle, and `busy` stays high.
- With no transfer at the last cycle: after edge k+F, `busy=0`, `sync=0`, `a_ser=0`.
- Reset mid-frame aborts immediately to reset values. The partial frame is discarded.
- Throughput: one operand pair per F cycles.

## Configuration
- Macro `BITSERIAL_TX_PAD_EN`.
- Defined: PAD state present, F = `W+PAD`. The array emits all `2W` product bits when `PAD>=W`.
- Undefined: PAD state and padding logic removed, F = `W`, `PAD` ignored. The caller must provide flush frames itself, e.g. an operand pair with `in_a=0`.

## Structure
- Package `bitserial_pkg` holds:
  - the state enum `tx_state_t` (IDLE, SHIFT, PAD);
  - the function `frame_len(W, PAD)`, used by this block and its bench.
- No sub-module. Shift register, counter and FSM live in one module; `in_ready` decode is inline.

## Test plan
Use W=8 and PAD=8 unless stated.
- **Single frame:** `in_a=0xB5`, `in_b=0x3C` accepted at edge 0. Expected:
  - `a_ser` over cycles 0..15 = 1,0,1,0,1,1,0,1, then eight 0s;
  - `sync` high only in cycle 0;
  - `b_par=0x3C` throughout;
  - `busy` high for 16 cycles, then low.
- **Back-to-back:** `in_valid` held high with `0xFF`/`0x01`, then `0x01`/`0xFF`. Expected:
  - second `sync` exactly 16 cycles after the first, with no idle cycle between;
  - `in_ready` high only in cycle 15 of each frame.
- **Stall:** `in_valid` asserted mid-frame with changing `in_a`. Expected: no effect until the last cycle, and the value present at the accepting edge is the one serialized.
- **Reset mid-frame:** `rst_n` pulled low at frame cycle 5. Expected:
  - outputs go to reset values asynchronously;
  - after release, a new transfer starts a clean frame with `sync=1`.
- **Macro undefined:** W=8. Expected:
  - frame is 8 cycles;
  - back-to-back `sync` spacing is 8;
  - `a_ser` equals the 8 operand bits with no zero tail.
- **End-to-end:** W=8, array of `serialmuladd`-style cells. Multiplying 13×11 must yield 143 collected from the serial product over 16 cycles.

Source files
------------

// File: rtl/bitserial_pkg.sv
// Shared types and helpers for the bit-serial multiply-add array front end.
//   tx_state_t : transmit FSM states (IDLE, SHIFT, PAD)
//   frame_len  : frame length in cycles for a given operand width / pad count
// Optional feature macro: BITSERIAL_TX_PAD_EN (zero-padding cycles after each operand).
package bitserial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } tx_state_t;

  // Cycles per frame. Without padding the pad count is ignored.
  function automatic int frame_len(input int w, input int pad);
`ifdef BITSERIAL_TX_PAD_EN
    return w + pad;
`else
    return w + (pad * 0);
`endif
  endfunction

endpackage

// File: rtl/bitserial_operand_tx.sv
// Transmit end of the LSB-first bit-serial multiply-add array.
// Accepts an operand pair over valid/ready, streams in_a LSB-first on a_ser
// while holding in_b on b_par for the whole frame. sync marks frame cycle 0.
// With BITSERIAL_TX_PAD_EN defined, PAD zero bits follow the operand so the
// full product flushes out of the array.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake (in_ready independent of in_valid)
//   in_a, in_b [W]      : serialized / parallel operands
//   a_ser, b_par, sync, busy : registered array-side outputs
module bitserial_operand_tx
  import bitserial_pkg::*;
#(
  parameter int W   = 8,
  parameter int PAD = W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         a_ser,
  output logic [W-1:0] b_par,
  output logic         sync,
  output logic         busy
);

  localparam int F  = frame_len(W, PAD);
  localparam int CW = (F > 1) ? $clog2(F) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(F - 1);
  localparam logic [CW-1:0] CNT_SHEND = CW'(W - 1);

  tx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [W-1:0]   b_par_q, b_par_d;
  logic           a_ser_q, a_ser_d;
  logic           sync_q, sync_d;
  logic           busy_q, busy_d;
  logic           last_cycle, xfer;

  // The counter runs 0..F-1 across SHIFT and PAD, so F-1 is only ever
  // reached in whichever state closes the frame.
  assign last_cycle = (state_q != IDLE) && (cnt_q == CNT_LAST);
  assign in_ready   = (state_q == IDLE) || last_cycle;
  assign xfer       = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    b_par_d = b_par_q;
    a_ser_d = 1'b0;
    sync_d  = 1'b0;
    busy_d  = 1'b0;
    if (xfer) begin
      // Bit 0 goes straight to the output; the register holds the rest.
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = in_a >> 1;
      a_ser_d = in_a[0];
      sync_d  = 1'b1;
      busy_d  = 1'b1;
      b_par_d = in_b;
    end else begin
      case (state_q)
        IDLE: ;
`ifdef BITSERIAL_TX_PAD_EN
        SHIFT, bitserial_pkg::PAD: begin
`else
        SHIFT: begin
`endif
          if (last_cycle) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            a_ser_d = sr_q[0];   // zeros shifted in form the pad tail
            sr_d    = sr_q >> 1;
            busy_d  = 1'b1;
`ifdef BITSERIAL_TX_PAD_EN
            if (state_q == SHIFT && cnt_q == CNT_SHEND) state_d = bitserial_pkg::PAD;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      b_par_q <= '0;
      a_ser_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      b_par_q <= b_par_d;
      a_ser_q <= a_ser_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
    end
  end

  assign a_ser = a_ser_q;
  assign b_par = b_par_q;
  assign sync  = sync_q;
  assign busy  = busy_q;

`ifndef BITSERIAL_TX_PAD_EN
  logic unused_shend;
  assign unused_shend = ^CNT_SHEND;
`endif

endmodule
